seg_scan: RTL and testbench

- Upstream feeder for the single-digit 7-segment decoder.
- Accepts a binary value on a load strobe and converts it to 4 BCD digits with a sequential double-dabble.
- Time-multiplexes those digits onto one 4-bit digit bus plus a one-hot digit-select.
- The digit bus and `seg_en` drive the decoder's `in` and `en`; `dig_sel` drives the display commons.

---
 rtl/seg_pkg.sv | 29 ++
 rtl/bin2bcd_seq.sv | 83 ++++++++
 rtl/seg_scan.sv | 95 +++++++++
 tb/tb_seg_scan.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants, digit array type, conversion FSM states and the
// double-dabble nibble adjust for the seg_scan display feeder.
package seg_pkg;

   localparam int NDIG    = 4;
   localparam int BCD_MAX = 9999;

   typedef logic [NDIG-1:0][3:0] bcd4_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // +3 on every nibble in 5..9; each nibble is independent, no carries.
   function automatic bcd4_t dd_adjust(input bcd4_t b);
      bcd4_t r;
      for (int i = 0; i < NDIG; i++) begin
         if ((b[i] >= 4'd5) && (b[i] <= 4'd9)) begin
            r[i] = b[i] + 4'd3;
         end else begin
            r[i] = b[i];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: saturates at 9999, runs one
// iteration per cycle and commits the BCD result to the display register.
module bin2bcd_seq
   import seg_pkg::*;
#(
   parameter int BIN_W = 14
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [BIN_W-1:0] bin_i,
   input  logic             load_i,
   output logic             busy_o,
   output logic             ovf_o,
   output bcd4_t            disp_o
);

   localparam int                BCD_W = 4 * NDIG;
   localparam int                SR_W  = BCD_W + BIN_W;
   localparam logic [BIN_W-1:0]  CLIP  = BIN_W'(BCD_MAX);
   localparam logic [3:0]        LAST  = 4'(BIN_W - 1);

   state_t           state_q;
   logic [SR_W-1:0]  sr_q;
   logic [SR_W-1:0]  sr_d;
   logic [3:0]       cnt_q;
   logic             sat_q;
   logic             busy_q;
   logic             ovf_q;
   bcd4_t            disp_q;
   logic             sat_d;
   logic [BIN_W-1:0] clip_d;

   assign sat_d  = (32'(bin_i) > 32'(BCD_MAX));
   assign clip_d = sat_d ? CLIP : bin_i;
   assign sr_d   = {dd_adjust(sr_q[SR_W-1 -: BCD_W]), sr_q[BIN_W-1:0]} << 1;

   // Conversion FSM: capture on load, BIN_W shift iterations, then commit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sr_q    <= '0;
         cnt_q   <= 4'd0;
         sat_q   <= 1'b0;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
         disp_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (load_i) begin
                  sr_q    <= {{BCD_W{1'b0}}, clip_d};
                  sat_q   <= sat_d;
                  cnt_q   <= 4'd0;
                  busy_q  <= 1'b1;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               sr_q  <= sr_d;
               cnt_q <= cnt_q + 4'd1;
               if (cnt_q == LAST) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               disp_q  <= sr_q[SR_W-1 -: BCD_W];
               ovf_q   <= sat_q;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy_o = busy_q;
   assign ovf_o  = ovf_q;
   assign disp_o = disp_q;

endmodule

// File: rtl/seg_scan.sv
// 4-digit BCD display scanner feeding a single 7-segment decoder.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_scan
   import seg_pkg::*;
#(
   parameter int BIN_W    = 14,
   parameter int SCAN_DIV = 50000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [BIN_W-1:0] bin,
   input  logic             load,
   output logic             busy,
   output logic             ovf,
   output logic [3:0]       digit,
   output logic             seg_en,
   output logic [3:0]       dig_sel
);

   localparam int             PRE_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

   bcd4_t            disp_s;
   logic [PRE_W-1:0] pre_q;
   logic [PRE_W-1:0] pre_d;
   logic [1:0]       idx_q;
   logic [1:0]       idx_d;
   logic [3:0]       digit_q;
   logic             seg_en_q;
   logic             seg_en_d;
   logic [3:0]       dig_sel_q;

   bin2bcd_seq #(.BIN_W(BIN_W)) u_conv (
      .clk    (clk),
      .rst_n  (rst_n),
      .bin_i  (bin),
      .load_i (load),
      .busy_o (busy),
      .ovf_o  (ovf),
      .disp_o (disp_s)
   );

   // Free-running prescaler; the digit index steps on its terminal count.
   always_comb begin
      pre_d = pre_q + {{(PRE_W-1){1'b0}}, 1'b1};
      idx_d = idx_q;
      if (pre_q == PRE_LAST) begin
         pre_d = '0;
         idx_d = idx_q + 2'd1;
      end else begin
         idx_d = idx_q;
      end
   end

`ifdef SEG_LZB_EN
   logic [1:0] msd_s;

   // Most-significant nonzero digit; digits above it are blanked.
   always_comb begin
      msd_s = 2'd0;
      for (int i = 1; i < NDIG; i++) begin
         if (disp_s[i] != 4'd0) begin
            msd_s = 2'(i);
         end else begin
            msd_s = msd_s;
         end
      end
      seg_en_d = (idx_d <= msd_s);
   end
`else
   assign seg_en_d = 1'b1;
`endif

   // Scan state and registered decoder/common outputs, aligned to idx_d.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q     <= '0;
         idx_q     <= 2'd0;
         digit_q   <= 4'd0;
         seg_en_q  <= 1'b0;
         dig_sel_q <= 4'b0001;
      end else begin
         pre_q     <= pre_d;
         idx_q     <= idx_d;
         digit_q   <= disp_s[idx_d];
         seg_en_q  <= seg_en_d;
         dig_sel_q <= 4'b0001 << idx_d;
      end
   end

   assign digit   = digit_q;
   assign seg_en  = seg_en_q;
   assign dig_sel = dig_sel_q;

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: loads push expected display values that a
// monitor checks across a full scan once the conversion commits.
module tb_seg_scan;

   localparam int BIN_W    = 14;
   localparam int SCAN_DIV = 4;
   localparam int BUSY_CYC = BIN_W + 1;
`ifdef SEG_LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   typedef struct {
      int val;
      bit ov;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             load = 1'b0;
   logic [BIN_W-1:0] bin = '0;
   logic             busy;
   logic             ovf;
   logic [3:0]       digit;
   logic             seg_en;
   logic [3:0]       dig_sel;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   logic prev_busy = 1'b0;

   always #5 clk = ~clk;

   seg_scan #(.BIN_W(BIN_W), .SCAN_DIV(SCAN_DIV)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bin     (bin),
      .load    (load),
      .busy    (busy),
      .ovf     (ovf),
      .digit   (digit),
      .seg_en  (seg_en),
      .dig_sel (dig_sel)
   );

   function automatic int dec_digit(input int v, input int i);
      int r = v;
      for (int k = 0; k < i; k++) r = r / 10;
      return r % 10;
   endfunction

   function automatic int exp_en(input int v, input int i);
      int nd = 1;
      int t  = v / 10;
      if (!LZB) return 1;
      while (t > 0) begin
         nd++;
         t = t / 10;
      end
      return (i < nd) ? 1 : 0;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_display(input int val, input bit ov);
      int idx;
      repeat (2) @(negedge clk);
      check("ovf", int'(ovf), int'(ov));
      for (int c = 0; c < 4 * SCAN_DIV; c++) begin
         @(negedge clk);
         check("dig_sel_onehot", int'($onehot(dig_sel)), 1);
         idx = (dig_sel == 4'b0010) ? 1 : (dig_sel == 4'b0100) ? 2 :
               (dig_sel == 4'b1000) ? 3 : 0;
         check($sformatf("digit[%0d] of %0d", idx, val), int'(digit), dec_digit(val, idx));
         check($sformatf("seg_en[%0d] of %0d", idx, val), int'(seg_en), exp_en(val, idx));
      end
   endtask

   task automatic push_exp(input int v);
      exp_t e;
      e.val = (v > 9999) ? 9999 : v;
      e.ov  = (v > 9999);
      sb_q.push_back(e);
   endtask

   task automatic pulse_load(input int v);
      @(posedge clk);
      #1;
      bin  = BIN_W'(v);
      load = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
   endtask

   task automatic wait_busy(output int n);
      n = 1;
      forever begin
         @(negedge clk);
         if (!busy) break;
         n++;
         if (n > 200) begin
            check("busy_timeout", n, BUSY_CYC);
            break;
         end
      end
      n = n - 1;
   endtask

   // intf < 0: clean load with busy-length check; else a second load after intf cycles
   task automatic run_load(input int v, input int intf, input int intf_v);
      int n;
      push_exp(v);
      pulse_load(v);
      if (intf < 0) begin
         wait_busy(n);
         check("busy_len", n, BUSY_CYC);
      end else begin
         repeat (intf) @(posedge clk);
         pulse_load(intf_v);
         wait_busy(n);
      end
      repeat (22) @(posedge clk);
   endtask

   // Monitor: each falling busy edge pops one expected result and scans it.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && prev_busy && !busy) begin
            if (sb_q.size() == 0) begin
               check("unexpected_commit", 1, 0);
            end else begin
               e = sb_q.pop_front();
               check_display(e.val, e.ov);
            end
         end
         prev_busy = busy;
      end
   end

   initial begin
      int v;
      #12;
      check("rst_busy", int'(busy), 0);
      check("rst_ovf", int'(ovf), 0);
      check("rst_digit", int'(digit), 0);
      check("rst_seg_en", int'(seg_en), 0);
      check("rst_dig_sel", int'(dig_sel), 1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int j = 1; j <= 16; j++) begin
         @(negedge clk);
         check("scan_dig_sel", int'(dig_sel), 1 << ((j / SCAN_DIV) % 4));
         check("idle_digit", int'(digit), 0);
         check("idle_seg_en", int'(seg_en), exp_en(0, (j / SCAN_DIV) % 4));
         check("idle_busy", int'(busy), 0);
      end

      run_load(1234, -1, 0);
      run_load(12000, -1, 0);
      run_load(7, -1, 0);
      run_load(1234, 4, 5678);
      run_load(5678, -1, 0);

      pulse_load(4321);
      repeat (7) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_busy", int'(busy), 0);
      check("abort_ovf", int'(ovf), 0);
      check("abort_digit", int'(digit), 0);
      check("abort_dig_sel", int'(dig_sel), 1);
      repeat (8) @(negedge clk);
      rst_n = 1'b1;
      check_display(0, 1'b0);

      run_load(42, -1, 0);
      run_load(0, -1, 0);
      run_load(1000, -1, 0);
      run_load(9999, -1, 0);
      run_load(10000, -1, 0);
      run_load(16383, -1, 0);
      for (int r = 0; r < 14; r++) begin
         v = (r % 2 == 0) ? int'($urandom_range(0, 16383)) : int'($urandom_range(0, 120));
         if (r % 3 == 0) begin
            run_load(v, int'($urandom_range(0, 9)), int'($urandom_range(0, 16383)));
         end else begin
            run_load(v, -1, 0);
         end
      end

      check("scoreboard_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
